instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Parametrised, loadable instruction memory with an integrated program counter and fetch sequencer. It replaces the fixed case-ROM: the program is written through a load port while idle, then fetched one word per cycle. Fetch supports stall, branch redirect with flush, and halt-on-opcode. The output feeds the decode stage in front of the ALU and register file.

Parameters:
INSTR_WIDTH, 9, instruction word width in bits
ADDR_WIDTH, 4, PC/address width; DEPTH = 2**ADDR_WIDTH words
OPCODE_WIDTH, 3, opcode field = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH]
HALT_OPCODE, 3'b111, opcode value that stops fetch
RESET_PC, 0, PC value loaded on reset and on each run start

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
loadEnable  in  1  write loadData into memory at loadAddress
loadAddress  in  ADDR_WIDTH  load write address
loadData  in  INSTR_WIDTH  load write data
run  in  1  one-cycle pulse that starts fetch from RESET_PC
stall  in  1  downstream not ready; hold all fetch outputs and PC
branchTaken  in  1  redirect PC to branchTarget and flush the presented word
branchTarget  in  ADDR_WIDTH  redirect address
instruction  out  INSTR_WIDTH  fetched word (registered)
pcOut  out  ADDR_WIDTH  address of the presented instruction
instrValid  out  1  instruction/pcOut are valid
halted  out  1  halt instruction accepted; fetch stopped
loadError  out  1  one-cycle pulse: load attempted during FETCH and ignored

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=RESET_PC, instruction=0, pcOut=0, instrValid=0, halted=0, loadError=0. Memory contents are not cleared by reset. Reset mid-fetch aborts immediately; no partial outputs remain.
- States: IDLE, FETCH, HALT.
- IDLE:
  - loadEnable writes mem[loadAddress]=loadData on the clock edge.
  - run: pc<=RESET_PC, state<=FETCH. If run and loadEnable coincide, the write happens and the state changes.
  - Outputs stay at their reset values.
- FETCH, with stall=0 and branchTaken=0:
  - instruction<=mem[pc], pcOut<=pc, instrValid<=1.
  - pc<=pc+1, wrapping modulo DEPTH (4'hF -> 4'h0).
  - Latency: 1 cycle from PC to output.
- FETCH, stall=1 and branchTaken=0: instruction, pcOut, instrValid and pc all hold.
- branchTaken=1 in FETCH, or in HALT with halted=0:
  - Takes priority over stall and over halt.
  - pc<=branchTarget, instrValid<=0 (flush), state<=FETCH.
  - The first target word is presented on the following cycle.
- Halt detection:
  - Applies in FETCH when a word is fetched (stall=0, branchTaken=0) and its opcode field == HALT_OPCODE.
  - The word is presented with instrValid=1, pc is not incremented, and state<=HALT.
- HALT:
  - While stall=1, the halt word stays presented.
  - On the first cycle with stall=0 and branchTaken=0: instrValid<=0, halted<=1.
  - Then frozen: pc, pcOut and instruction hold.
  - loadEnable writes memory.
  - run: halted<=0, pc<=RESET_PC, state<=FETCH.
- loadEnable in FETCH: the write is ignored and loadError pulses for 1 cycle. loadError is 0 in all other cases.
- run in FETCH is ignored.

Decomposition:
- Package instr_fetch_pkg:
  - state enum {IDLE, FETCH, HALT}.
  - Default widths (INSTR_WIDTH=9, ADDR_WIDTH=4, OPCODE_WIDTH=3).
  - HALT_OPCODE, plus opcode constants shared with the decoder (LI=3'b101).
- Sub-module instr_mem_array:
  - DEPTH x INSTR_WIDTH.
  - One synchronous write port and one read port.
  - Read data is registered by the fetch logic.
- The top module holds the FSM, PC, and output registers.

Test Plan:
1. Load mem[0..3] = 9'b101_00_0011, 9'b101_01_0110, 9'b101_10_0111, 9'b101_11_1001, then pulse run -> on 4 consecutive cycles after run: pcOut=0..3, instruction matches each word, instrValid=1.
2. Fetch running, stall=1 for 3 cycles while pcOut=2 -> instruction=mem[2], pcOut=2, instrValid=1 held for 3 cycles; the next cycle after release shows pcOut=3.
3. branchTaken=1, branchTarget=4'hA while pcOut=1 (plus simultaneous stall=1) -> the next cycle has instrValid=0; the cycle after has pcOut=10, instruction=mem[10].
4. mem[5]=9'b111_000000, run from 0 -> pcOut=5 presented with instrValid=1; the next cycle has instrValid=0, halted=1, pcOut=5 held; a later run restarts at pcOut=0 with halted=0.
5. Fill memory with no halt, run for 18 fetches -> pcOut sequence ...14, 15, 0, 1 (wrap).
6. loadEnable during FETCH at address 3 -> loadError=1 for one cycle and mem[3] unchanged. Reset asserted mid-fetch -> the next cycle shows all outputs 0, state IDLE, and earlier loaded words still read back after run.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and the decode stage.
package instr_fetch_pkg;

    // Default geometry of the instruction store.
    localparam int DEF_INSTR_WIDTH  = 9;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_OPCODE_WIDTH = 3;

    // Opcodes shared with the decoder.
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_LI   = 3'b101;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_HALT = 3'b111;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x INSTR_WIDTH instruction store: one synchronous write port, one
// combinational read port whose data is registered by the fetch logic.
module instr_mem_array
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [INSTR_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [INSTR_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    // Write port: program load.
    // NOTE: the array has no reset on purpose; the loaded program must survive a
    // reset, and a reset on a RAM array prevents it mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Loadable instruction memory with program counter and fetch sequencer
// (stall, branch redirect with flush, halt on opcode).
module instr_fetch_unit
    import instr_fetch_pkg::*;
#(
    parameter int                          INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int                          ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                          OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE  = OPC_HALT,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC     = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loadEnable,
    input  logic [ADDR_WIDTH-1:0]  loadAddress,
    input  logic [INSTR_WIDTH-1:0] loadData,
    input  logic                   run,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [ADDR_WIDTH-1:0]  branchTarget,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  pcOut,
    output logic                   instrValid,
    output logic                   halted,
    output logic                   loadError
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

    fetch_state_e           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  pc_out_q;
    logic                   valid_q;
    logic                   halted_q;
    logic                   load_err_q;

    logic                   mem_we;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0]  pc_inc_d;
    logic                   is_halt_d;

    // Loads are only accepted while the sequencer is not fetching.
    assign mem_we    = loadEnable && (state_q != FETCH) && !reset;
    assign pc_inc_d  = pc_q + PC_STEP;   // wraps modulo DEPTH naturally
    assign is_halt_d = (mem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

    instr_mem_array #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_we),
        .wr_addr_i (loadAddress),
        .wr_data_i (loadData),
        .rd_addr_i (pc_q),
        .rd_data_o (mem_rdata)
    );

    // Fetch FSM, program counter and registered outputs.
    // NOTE: every assignment here is non-blocking so all registers update from
    // the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= loadEnable && (state_q == FETCH);
            case (state_q)
                IDLE: begin
                    if (run) begin
                        pc_q    <= RESET_PC;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (branchTaken) begin
                        pc_q    <= branchTarget;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        instr_q  <= mem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        if (is_halt_d) begin
                            state_q <= HALT;
                        end else begin
                            pc_q <= pc_inc_d;
                        end
                    end
                end
                HALT: begin
                    if (!halted_q && branchTaken) begin
                        pc_q    <= branchTarget;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (halted_q && run) begin
                        halted_q <= 1'b0;
                        pc_q     <= RESET_PC;
                        state_q  <= FETCH;
                    end else if (!halted_q && !stall) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instruction = instr_q;
    assign pcOut       = pc_out_q;
    assign instrValid  = valid_q;
    assign halted      = halted_q;
    assign loadError   = load_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset, loadEnable, run, stall, branchTaken;
    logic [3:0] loadAddress, branchTarget;
    logic [8:0] loadData;
    logic [8:0] instruction;
    logic [3:0] pcOut;
    logic       instrValid, halted, loadError;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .loadEnable   (loadEnable),
        .loadAddress  (loadAddress),
        .loadData     (loadData),
        .run          (run),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .instruction  (instruction),
        .pcOut        (pcOut),
        .instrValid   (instrValid),
        .halted       (halted),
        .loadError    (loadError)
    );

    // Behavioural model: program image, a mode, the next address to fetch and
    // what is currently presented to decode.
    typedef enum {M_IDLE, M_FETCH, M_HALT} mode_t;
    mode_t      m_mode;
    logic [8:0] m_mem [16];
    int         m_pc;
    logic [8:0] m_instr;
    int         m_pcout;
    logic       m_valid, m_halted, m_lerr;
    logic [8:0] words [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [8:0] w;
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_instr = '0; m_pcout = 0;
            m_valid = 1'b0; m_halted = 1'b0; m_lerr = 1'b0;
        end else begin
            m_lerr = loadEnable && (m_mode == M_FETCH);
            if (loadEnable && m_mode != M_FETCH) m_mem[loadAddress] = loadData;
            case (m_mode)
                M_IDLE: if (run) begin m_pc = 0; m_mode = M_FETCH; end
                M_FETCH: begin
                    if (branchTaken) begin
                        m_pc = int'(branchTarget); m_valid = 1'b0;
                    end else if (!stall) begin
                        w = m_mem[m_pc];
                        m_instr = w; m_pcout = m_pc; m_valid = 1'b1;
                        if (w[8:6] == 3'b111) m_mode = M_HALT;
                        else m_pc = (m_pc + 1) % 16;
                    end
                end
                M_HALT: begin
                    if (!m_halted && branchTaken) begin
                        m_pc = int'(branchTarget); m_valid = 1'b0; m_mode = M_FETCH;
                    end else if (m_halted && run) begin
                        m_halted = 1'b0; m_pc = 0; m_mode = M_FETCH;
                    end else if (!m_halted && !stall) begin
                        m_valid = 1'b0; m_halted = 1'b1;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("instruction", instruction, m_instr);
        check("pcOut", pcOut, m_pcout);
        check("instrValid", instrValid, m_valid);
        check("halted", halted, m_halted);
        check("loadError", loadError, m_lerr);
    endtask

    task automatic step(input logic rs, input logic le, input logic [3:0] la, input logic [8:0] ld,
                        input logic rn, input logic st, input logic br, input logic [3:0] bt);
        reset = rs; loadEnable = le; loadAddress = la; loadData = ld;
        run = rn; stall = st; branchTaken = br; branchTarget = bt;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();                  step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();              step(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic run_pulse();             step(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic load_word(input logic [3:0] a, input logic [8:0] d); step(0, 1, a, d, 0, 0, 0, 0); endtask

    initial begin
        words[0] = 9'b101_00_0011;
        words[1] = 9'b101_01_0110;
        words[2] = 9'b101_10_0111;
        words[3] = 9'b101_11_1001;
        for (int i = 4; i < 16; i++) words[i] = {3'b101, 6'(i)};

        // Reset and program load.
        do_reset();
        for (int i = 0; i < 16; i++) load_word(4'(i), words[i]);

        // Sequential fetch, then stall while word 2 is presented.
        run_pulse();
        for (int i = 0; i < 3; i++) begin
            idle();
            check("seq_pc", pcOut, i);
            check("seq_instr", instruction, words[i]);
            check("seq_valid", instrValid, 1);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0);
            check("stall_pc", pcOut, 2);
            check("stall_instr", instruction, words[2]);
            check("stall_valid", instrValid, 1);
        end
        idle();
        check("release_pc", pcOut, 3);

        // Branch with simultaneous stall.
        do_reset();
        run_pulse();
        idle();
        idle();
        check("pre_branch_pc", pcOut, 1);
        step(0, 0, 0, 0, 0, 1, 1, 4'hA);
        check("flush_valid", instrValid, 0);
        idle();
        check("target_pc", pcOut, 10);
        check("target_instr", instruction, words[10]);
        check("target_valid", instrValid, 1);

        // Halt on opcode, then restart.
        do_reset();
        load_word(4'd5, 9'b111_000000);
        run_pulse();
        for (int i = 0; i < 6; i++) idle();
        check("halt_word_pc", pcOut, 5);
        check("halt_word_valid", instrValid, 1);
        check("halt_word", instruction, 9'b111_000000);
        idle();
        check("halted_flag", halted, 1);
        check("halted_valid", instrValid, 0);
        check("halted_pc", pcOut, 5);
        idle();
        check("frozen_pc", pcOut, 5);
        run_pulse();
        check("restart_halted", halted, 0);
        idle();
        check("restart_pc", pcOut, 0);
        check("restart_valid", instrValid, 1);

        // PC wrap over 18 fetches.
        do_reset();
        load_word(4'd5, words[5]);
        run_pulse();
        for (int k = 0; k < 18; k++) begin
            idle();
            check("wrap_pc", pcOut, k % 16);
        end

        // Load during fetch is rejected; reset mid-fetch keeps memory.
        step(0, 1, 4'd3, 9'h1FF, 0, 0, 0, 0);
        check("load_err_pulse", loadError, 1);
        idle();
        check("load_err_clear", loadError, 0);
        check("mem3_pc", pcOut, 3);
        check("mem3_kept", instruction, words[3]);
        do_reset();
        check("rst_instr", instruction, 0);
        check("rst_pc", pcOut, 0);
        check("rst_valid", instrValid, 0);
        idle();
        check("idle_valid", instrValid, 0);
        run_pulse();
        for (int i = 0; i < 4; i++) begin
            idle();
            check("reload_instr", instruction, words[i]);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic rs, le, rn;
            rs = ($urandom_range(0, 79) == 0);
            le = !rs && ($urandom_range(0, 4) == 0);
            rn = ((m_mode != M_HALT) || m_halted) && ($urandom_range(0, 3) == 0);
            step(rs, le, 4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)), rn,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
